// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU option encodings,
// the hard-wired zero register index and the default datapath widths.
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_REG_BITS   = 5;
  localparam int REG_ZERO           = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, forwarding-source and alu-side signals of the issue stage.
// The master is the surrounding pipeline; the slave is the issue stage.
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = mips_pkg::DEFAULT_DATA_WIDTH,
  parameter int REG_BITS   = mips_pkg::DEFAULT_REG_BITS
);
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_BITS-1:0]   in_rs_idx;
  logic [REG_BITS-1:0]   in_rt_idx;
  logic [DATA_WIDTH-1:0] in_rs_data;
  logic [DATA_WIDTH-1:0] in_rt_data;
  logic [DATA_WIDTH-1:0] in_imm;
  logic                  in_alu_src;
  logic [1:0]            in_alu_op;
  logic [REG_BITS-1:0]   in_rd_idx;
  logic                  in_reg_write;
  logic                  mem_we;
  logic [REG_BITS-1:0]   mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  wb_we;
  logic [REG_BITS-1:0]   wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [1:0]            alu_option;
  logic [REG_BITS-1:0]   out_rd_idx;
  logic                  out_reg_write;

  modport master (
    output in_valid, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_alu_op, in_rd_idx, in_reg_write,
           mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_option, out_rd_idx, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_alu_op, in_rd_idx, in_reg_write,
           mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_option, out_rd_idx, out_reg_write
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Selects the freshest value of one source register: $0 is always zero,
// otherwise EX/MEM beats MEM/WB, which beats the held regfile read.
module operand_fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_BITS   = DEFAULT_REG_BITS
) (
  input  logic [REG_BITS-1:0]   idx,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic                  mem_we,
  input  logic [REG_BITS-1:0]   mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wb_we,
  input  logic [REG_BITS-1:0]   wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] val
);

  always_comb begin
    val = reg_val;
    if (idx == REG_BITS'(REG_ZERO)) begin
      val = '0;
    end else if (mem_we && (mem_rd == idx)) begin
      val = mem_data;
    end else if (wb_we && (wb_rd == idx)) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register in front of the alu: one-deep valid/ready slot with flush,
// operand forwarding on the output side and WB refresh of held operands.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_BITS   = DEFAULT_REG_BITS
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_stage_if.slave bus
);

  // Operand slot 0 is rs (feeds A), slot 1 is rt (feeds B when alu_src=0).
  logic                        valid_reg;
  logic [1:0][REG_BITS-1:0]    idx_reg;
  logic [1:0][DATA_WIDTH-1:0]  data_reg;
  logic [DATA_WIDTH-1:0]       imm_reg;
  logic                        src_reg;
  alu_op_e                     op_reg;
  logic [REG_BITS-1:0]         rd_reg;
  logic                        rw_reg;

  logic [1:0][REG_BITS-1:0]    in_idx;
  logic [1:0][DATA_WIDTH-1:0]  in_data;
  logic [1:0][DATA_WIDTH-1:0]  cap_data;
  logic [1:0][DATA_WIDTH-1:0]  held_next;
  logic [1:0][DATA_WIDTH-1:0]  fwd_val;
  logic                        accept;
  logic                        hold;

  assign bus.in_ready = !valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign hold         = valid_reg && !bus.out_ready;

  assign in_idx[0]  = bus.in_rs_idx;
  assign in_idx[1]  = bus.in_rt_idx;
  assign in_data[0] = bus.in_rs_data;
  assign in_data[1] = bus.in_rt_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      // A same-cycle regfile write is not yet visible in the read data, so take it from WB.
      assign cap_data[gi] = (bus.wb_we && (bus.wb_rd == in_idx[gi]) &&
                             (in_idx[gi] != REG_BITS'(REG_ZERO))) ? bus.wb_data : in_data[gi];
      // While stalled, absorb the WB write so the value survives the producer retiring.
      assign held_next[gi] = (bus.wb_we && (bus.wb_rd == idx_reg[gi]) &&
                              (idx_reg[gi] != REG_BITS'(REG_ZERO))) ? bus.wb_data : data_reg[gi];

      operand_fwd_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_BITS  (REG_BITS)
      ) u_fwd (
        .idx     (idx_reg[gi]),
        .reg_val (data_reg[gi]),
        .mem_we  (bus.mem_we),
        .mem_rd  (bus.mem_rd),
        .mem_data(bus.mem_data),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_data (bus.wb_data),
        .val     (fwd_val[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
      imm_reg   <= '0;
      src_reg   <= 1'b0;
      op_reg    <= ALU_ADD;
      rd_reg    <= '0;
      rw_reg    <= 1'b0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      idx_reg   <= in_idx;
      data_reg  <= cap_data;
      imm_reg   <= bus.in_imm;
      src_reg   <= bus.in_alu_src;
      op_reg    <= alu_op_e'(bus.in_alu_op);
      rd_reg    <= bus.in_rd_idx;
      rw_reg    <= bus.in_reg_write;
    end else if (hold) begin
      data_reg  <= held_next;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid     = valid_reg;
  assign bus.alu_a         = fwd_val[0];
  assign bus.alu_b         = src_reg ? imm_reg : fwd_val[1];
  assign bus.alu_option    = op_reg;
  assign bus.out_rd_idx    = rd_reg;
  assign bus.out_reg_write = valid_reg && rw_reg;

endmodule
